imem_responder: RTL and testbench

Instruction-memory responder for the Mips32 core's fetch interface. The core drives word address raddr (pc>>2) and consumes instr combinationally in the same cycle. This block answers those fetches from an internal word array. The array is filled by a valid/ready program-load stream, and a small state machine gates when the core sees real instructions.

---
 rtl/imem_pkg.sv | 10 +
 rtl/imem_array.sv | 20 ++
 rtl/imem_responder.sv | 97 +++++++++
 tb/tb_imem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory responder.
package imem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/imem_array.sv
// Word array: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (wen) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program-load stream fills the array, fetches
// are answered combinationally while in RUN.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic [31:0]           raddr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  run,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fault
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  fault_q, fault_d;
  logic                  xfer, hit;
  logic [DATA_WIDTH-1:0] rdata;

  // Restart has priority: a word presented alongside load_start is dropped.
  assign xfer = load_valid && (state_q == LOAD) && !load_start;
  assign hit  = (raddr < 32'(count_q)) && (raddr[31:ADDR_WIDTH] == '0);

  imem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clock (clock),
    .wen   (xfer),
    .waddr (wptr_q),
    .wdata (load_data),
    .raddr (raddr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (load_start) begin
        state_d = LOAD;
        wptr_d  = '0;
        count_d = '0;
        fault_d = 1'b0;
      end
      LOAD: if (load_start) begin
        wptr_d  = '0;
        count_d = '0;
        fault_d = 1'b0;
      end else if (xfer) begin
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
        // Full array ends the load even without load_last; wptr never reused.
        if (load_last || count_q == (ADDR_WIDTH+1)'(DEPTH-1)) state_d = RUN;
      end
      RUN: if (load_start) begin
        state_d = LOAD;
        wptr_d  = '0;
        count_d = '0;
        fault_d = 1'b0;
      end else if (!hit) begin
        fault_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign load_ready = (state_q == LOAD);
  assign run        = (state_q == RUN);
  assign count      = count_q;
  assign fault      = fault_q;
  assign instr      = (run && hit) ? rdata : DATA_WIDTH'(NOP_WORD);
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a load/fetch scoreboard.
module tb_imem_responder;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_start, load_valid, load_last;
  logic        load_ready, run, fault;
  logic [31:0] load_data, raddr, instr;
  logic [6:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } sb_t;
  sb_t sb[$];

  int total = 0;
  int bad   = 0;
  int widx  = 0;

  imem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .raddr      (raddr),
    .instr      (instr),
    .run        (run),
    .count      (count),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    widx = 0;
    sb.delete();
  endtask

  // Present one word for one cycle; record it as expected if it should be taken.
  task automatic send(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    chk("ready_on_send", {31'b0, load_ready}, 32'd1);
    sb.push_back('{a: 32'(widx), d: d});
    widx++;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr = e.a;
      #1;
      chk("fetch", instr, e.d);
      step();
    end
  endtask

  initial begin
    reset_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; raddr = 32'd5;
    #2;
    chk("rst_run",   {31'b0, run},        32'd0);
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_count", 32'(count),          32'd0);
    chk("rst_fault", {31'b0, fault},      32'd0);
    chk("rst_instr", instr,               32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("idle_run", {31'b0, run}, 32'd0);
    chk("idle_instr", instr, 32'd0);

    // Basic three-word program
    raddr = 32'd0;
    start_load();
    chk("load_run", {31'b0, run}, 32'd0);
    chk("load_instr", instr, 32'd0);
    send(32'h2001_0005, 1'b0);
    send(32'h2002_0007, 1'b0);
    chk("pre_last_run", {31'b0, run}, 32'd0);
    send(32'h0000_000D, 1'b1);
    chk("basic_run",   {31'b0, run}, 32'd1);
    chk("basic_count", 32'(count),   32'd3);
    chk("basic_ready", {31'b0, load_ready}, 32'd0);
    drain();
    chk("no_fault", {31'b0, fault}, 32'd0);
    raddr = 32'd3;
    #1 chk("unloaded_instr", instr, 32'd0);
    step();
    chk("fault_set", {31'b0, fault}, 32'd1);
    raddr = 32'h40;
    #1 chk("oor_instr", instr, 32'd0);
    step();
    chk("fault_hold", {31'b0, fault}, 32'd1);

    // Restart from RUN, then a gapped load
    raddr = 32'd0;
    start_load();
    chk("rs_run",   {31'b0, run},        32'd0);
    chk("rs_fault", {31'b0, fault},      32'd0);
    chk("rs_count", 32'(count),          32'd0);
    chk("rs_ready", {31'b0, load_ready}, 32'd1);
    send(32'hAAAA_0001, 1'b0);
    load_data = 32'hDEAD_BEEF;
    step();
    chk("gap_count", 32'(count), 32'd1);
    send(32'hBBBB_0002, 1'b1);
    chk("gap_count2", 32'(count), 32'd2);
    chk("gap_run", {31'b0, run}, 32'd1);
    drain();
    raddr = 32'd2;
    #1 chk("gap_addr2", instr, 32'd0);

    // Restart with a same-cycle word: the word is dropped
    start_load();
    send(32'h1111_1111, 1'b0);
    load_start = 1'b1; load_valid = 1'b1; load_data = 32'h2222_2222;
    step();
    load_start = 1'b0; load_valid = 1'b0;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_state", {31'b0, load_ready}, 32'd1);
    sb.delete();
    widx = 0;

    // Fill all 64 words without load_last
    for (int i = 0; i < 64; i++) send(32'hC000_0000 | 32'(i * 7 + 1), 1'b0);
    chk("full_run",   {31'b0, run}, 32'd1);
    chk("full_count", 32'(count),   32'd64);
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF;
    #1 chk("full_ready", {31'b0, load_ready}, 32'd0);
    step();
    load_valid = 1'b0;
    chk("full_count2", 32'(count), 32'd64);
    raddr = 32'd63;
    #1 chk("full_last", instr, 32'hC000_0000 | 32'(63 * 7 + 1));
    drain();
    chk("full_nofault", {31'b0, fault}, 32'd0);
    raddr = 32'd64;
    #1 chk("full_oor", instr, 32'd0);
    raddr = 32'h1000_0005;
    #1 chk("hi_bits", instr, 32'd0);
    step();
    chk("full_fault", {31'b0, fault}, 32'd1);

    // Reset in the middle of a load
    raddr = 32'd0;
    start_load();
    send(32'h3333_0000, 1'b0);
    send(32'h3333_0001, 1'b0);
    chk("mid_count", 32'(count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count),          32'd0);
    chk("mid_rst_ready", {31'b0, load_ready}, 32'd0);
    chk("mid_rst_run",   {31'b0, run},        32'd0);
    chk("mid_rst_fault", {31'b0, fault},      32'd0);
    sb.delete();
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", {31'b0, load_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
